// File: rtl/rob_commit_pkg.sv
// Shared configuration for the reorder buffer: sizes, bus types, instruction kinds
// and the conversions between entry index and rename tag.
package rob_commit_pkg;

    localparam int DEPTH  = 16;
    localparam int NICK_W = 5;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int DATA_W = 32;
    localparam int NAME_W = 5;

    typedef logic [NICK_W-1:0] nick_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [NAME_W-1:0] name_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam nick_t NICK_NONE = {NICK_W{1'b0}};

    typedef enum logic [1:0] {
        KIND_ALU    = 2'd0,
        KIND_STORE  = 2'd1,
        KIND_BRANCH = 2'd2
    } kind_e;

    // Tag 0 is reserved for "no pending producer", so tags are offset by one.
    function automatic nick_t nick_of(input idx_t idx);
        return nick_t'(idx) + nick_t'(1'b1);
    endfunction

    function automatic idx_t idx_of(input nick_t nick);
        return idx_t'(nick - nick_t'(1'b1));
    endfunction

endpackage

// File: rtl/rob_commit_ptr.sv
// Head/tail/occupancy bookkeeping for the reorder buffer circular array.
module rob_ptr
    import rob_commit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic             retire,
    input  logic             flush,
    output logic [IDX_W-1:0] head,
    output logic [IDX_W-1:0] tail,
    output logic             full
);

    idx_t head_q, head_d;
    idx_t tail_q, tail_d;
    cnt_t count_q, count_d;

    // Next pointer values; a flush empties the buffer regardless of other events.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = {IDX_W{1'b0}};
            tail_d  = {IDX_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (retire) begin
                head_d = head_q + idx_t'(1'b1);
            end else begin
                head_d = head_q;
            end
            if (alloc) begin
                tail_d = tail_q + idx_t'(1'b1);
            end else begin
                tail_d = tail_q;
            end
            case ({alloc, retire})
                2'b10:   count_d = count_q + cnt_t'(1'b1);
                2'b01:   count_d = count_q - cnt_t'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= {IDX_W{1'b0}};
            tail_q  <= {IDX_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head = head_q;
    assign tail = tail_q;
    assign full = (count_q == cnt_t'(DEPTH));

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: hands out rename tags at dispatch, captures CDB results and
// retires in program order, flushing the pipeline on a mispredicted branch.
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iDP_en,
    input  logic [NAME_W-1:0] iDP_rd_regnm,
    input  logic [1:0]        iDP_kind,
    input  logic              iDP_pd,
    output logic [NICK_W-1:0] oDP_nick,
    output logic              oFull,
    output logic              oRF_nick_en,
    output logic [NAME_W-1:0] oRF_nick_regnm,
    output logic [NICK_W-1:0] oRF_nick,
    input  logic              iCDB_en,
    input  logic [NICK_W-1:0] iCDB_nick,
    input  logic [DATA_W-1:0] iCDB_dt,
    input  logic              iCDB_jump,
    input  logic [DATA_W-1:0] iCDB_target,
    output logic              oRF_en,
    output logic [NAME_W-1:0] oRF_rd_regnm,
    output logic [DATA_W-1:0] oRF_rd_dt,
    output logic [NICK_W-1:0] oRF_rd_nick,
    output logic              oLSB_commit_en,
    output logic [NICK_W-1:0] oLSB_commit_nick,
    output logic              oClr,
    output logic [DATA_W-1:0] oClr_pc
);

    idx_t head_s, tail_s, cdb_idx_s;
    logic full_s, accept_s, cdb_wr_s, retire_s, flush_s;

    logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
    logic [DEPTH-1:0] pd_q, pd_d, jump_q, jump_d;
    kind_e kind_q   [DEPTH];
    kind_e kind_d   [DEPTH];
    name_t rd_q     [DEPTH];
    name_t rd_d     [DEPTH];
    data_t value_q  [DEPTH];
    data_t value_d  [DEPTH];
    data_t target_q [DEPTH];
    data_t target_d [DEPTH];

    logic  rf_en_q, rf_en_d, lsb_en_q, lsb_en_d, clr_q, clr_d;
    name_t rf_rd_q, rf_rd_d;
    data_t rf_dt_q, rf_dt_d, clr_pc_q, clr_pc_d;
    nick_t rf_nick_q, rf_nick_d, lsb_nick_q, lsb_nick_d;

    rob_ptr u_ptr (
        .clk    (clk),
        .rst    (rst),
        .alloc  (accept_s),
        .retire (retire_s),
        .flush  (flush_s),
        .head   (head_s),
        .tail   (tail_s),
        .full   (full_s)
    );

    // Retirement reads ready from state, so a CDB beat to the head commits one edge later.
    assign retire_s  = rdy && busy_q[head_s] && ready_q[head_s];
    assign flush_s   = retire_s && (kind_q[head_s] == KIND_BRANCH) && (jump_q[head_s] != pd_q[head_s]);
    assign accept_s  = rdy && iDP_en && !full_s && !flush_s;
    assign cdb_wr_s  = rdy && iCDB_en && (iCDB_nick != NICK_NONE);
    assign cdb_idx_s = idx_of(iCDB_nick);

    assign oDP_nick       = nick_of(tail_s);
    assign oFull          = full_s;
    assign oRF_nick_en    = accept_s && (iDP_kind != KIND_STORE) && (iDP_rd_regnm != 5'd0);
    assign oRF_nick_regnm = iDP_rd_regnm;
    assign oRF_nick       = nick_of(tail_s);

    // Per-entry update: flush, then allocate, retire, and finally CDB capture.
    always_comb begin
        busy_d   = busy_q;
        ready_d  = ready_q;
        pd_d     = pd_q;
        jump_d   = jump_q;
        kind_d   = kind_q;
        rd_d     = rd_q;
        value_d  = value_q;
        target_d = target_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_s) begin
                busy_d[i]  = 1'b0;
                ready_d[i] = 1'b0;
            end else if (accept_s && (tail_s == idx_t'(i))) begin
                busy_d[i]  = 1'b1;
                ready_d[i] = 1'b0;
                kind_d[i]  = kind_e'(iDP_kind);
                rd_d[i]    = iDP_rd_regnm;
                pd_d[i]    = iDP_pd;
            end else if (retire_s && (head_s == idx_t'(i))) begin
                busy_d[i]  = 1'b0;
                ready_d[i] = 1'b0;
            end else if (cdb_wr_s && (cdb_idx_s == idx_t'(i))) begin
                ready_d[i]  = 1'b1;
                value_d[i]  = iCDB_dt;
                jump_d[i]   = iCDB_jump;
                target_d[i] = iCDB_target;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // Commit outputs for the entry leaving the head this cycle.
    always_comb begin
        rf_en_d    = 1'b0;
        rf_rd_d    = 5'd0;
        rf_dt_d    = 32'd0;
        rf_nick_d  = NICK_NONE;
        lsb_en_d   = 1'b0;
        lsb_nick_d = NICK_NONE;
        clr_d      = 1'b0;
        clr_pc_d   = 32'd0;
        if (retire_s) begin
            case (kind_q[head_s])
                KIND_STORE: begin
                    lsb_en_d   = 1'b1;
                    lsb_nick_d = nick_of(head_s);
                end
                KIND_BRANCH: begin
                    clr_d    = flush_s;
                    clr_pc_d = flush_s ? target_q[head_s] : 32'd0;
                end
                default: begin
                    clr_d = 1'b0;
                end
            endcase
            // Branches may carry a link register write alongside the flush.
            if ((kind_q[head_s] != KIND_STORE) && (rd_q[head_s] != 5'd0)) begin
                rf_en_d   = 1'b1;
                rf_rd_d   = rd_q[head_s];
                rf_dt_d   = value_q[head_s];
                rf_nick_d = nick_of(head_s);
            end else begin
                rf_en_d = 1'b0;
            end
        end else begin
            rf_en_d = 1'b0;
        end
    end

    // Entry array state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= {DEPTH{1'b0}};
            ready_q <= {DEPTH{1'b0}};
            pd_q    <= {DEPTH{1'b0}};
            jump_q  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                kind_q[i]   <= KIND_ALU;
                rd_q[i]     <= 5'd0;
                value_q[i]  <= 32'd0;
                target_q[i] <= 32'd0;
            end
        end else begin
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            pd_q     <= pd_d;
            jump_q   <= jump_d;
            kind_q   <= kind_d;
            rd_q     <= rd_d;
            value_q  <= value_d;
            target_q <= target_d;
        end
    end

    // Registered commit and flush outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_en_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_dt_q    <= 32'd0;
            rf_nick_q  <= NICK_NONE;
            lsb_en_q   <= 1'b0;
            lsb_nick_q <= NICK_NONE;
            clr_q      <= 1'b0;
            clr_pc_q   <= 32'd0;
        end else begin
            rf_en_q    <= rf_en_d;
            rf_rd_q    <= rf_rd_d;
            rf_dt_q    <= rf_dt_d;
            rf_nick_q  <= rf_nick_d;
            lsb_en_q   <= lsb_en_d;
            lsb_nick_q <= lsb_nick_d;
            clr_q      <= clr_d;
            clr_pc_q   <= clr_pc_d;
        end
    end

    assign oRF_en           = rf_en_q;
    assign oRF_rd_regnm     = rf_rd_q;
    assign oRF_rd_dt        = rf_dt_q;
    assign oRF_rd_nick      = rf_nick_q;
    assign oLSB_commit_en   = lsb_en_q;
    assign oLSB_commit_nick = lsb_nick_q;
    assign oClr             = clr_q;
    assign oClr_pc          = clr_pc_q;

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: a vector table for single-instruction
// lifecycles plus directed sequences, with an in-order commit scoreboard.
module tb_rob_commit;
    import rob_commit_pkg::*;

    logic clk = 1'b0;
    logic rst, rdy;
    logic iDP_en, iDP_pd;
    logic [4:0] iDP_rd_regnm;
    logic [1:0] iDP_kind;
    logic [4:0] oDP_nick, oRF_nick_regnm, oRF_nick;
    logic oFull, oRF_nick_en;
    logic iCDB_en, iCDB_jump;
    logic [4:0] iCDB_nick;
    logic [31:0] iCDB_dt, iCDB_target;
    logic oRF_en, oLSB_commit_en, oClr;
    logic [4:0] oRF_rd_regnm, oRF_rd_nick, oLSB_commit_nick;
    logic [31:0] oRF_rd_dt, oClr_pc;

    always #5 clk = ~clk;

    rob_commit dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iDP_en(iDP_en), .iDP_rd_regnm(iDP_rd_regnm), .iDP_kind(iDP_kind), .iDP_pd(iDP_pd),
        .oDP_nick(oDP_nick), .oFull(oFull), .oRF_nick_en(oRF_nick_en),
        .oRF_nick_regnm(oRF_nick_regnm), .oRF_nick(oRF_nick),
        .iCDB_en(iCDB_en), .iCDB_nick(iCDB_nick), .iCDB_dt(iCDB_dt),
        .iCDB_jump(iCDB_jump), .iCDB_target(iCDB_target),
        .oRF_en(oRF_en), .oRF_rd_regnm(oRF_rd_regnm), .oRF_rd_dt(oRF_rd_dt), .oRF_rd_nick(oRF_rd_nick),
        .oLSB_commit_en(oLSB_commit_en), .oLSB_commit_nick(oLSB_commit_nick),
        .oClr(oClr), .oClr_pc(oClr_pc)
    );

    typedef struct {
        logic        st;
        logic [4:0]  rd;
        logic [31:0] dt;
        logic [4:0]  nick;
    } exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  kind;
        logic        pd;
        logic        jump;
        logic [31:0] dt;
        logic [4:0]  exp_nick;
        logic        exp_nen;
        logic        exp_rf;
        logic        exp_lsb;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Commit monitor: every commit beat must match the oldest expected retirement.
    always @(negedge clk) begin
        if (!rst && (oRF_en === 1'b1 || oLSB_commit_en === 1'b1)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: rf_en %b lsb_en %b rf_nick %0d lsb_nick %0d expected no commit",
                         oRF_en, oLSB_commit_en, oRF_rd_nick, oLSB_commit_nick);
            end else begin
                mon_e = sb.pop_front();
                check("commit_kind", {30'd0, oLSB_commit_en, oRF_en}, mon_e.st ? 32'd2 : 32'd1);
                if (mon_e.st) begin
                    check("lsb_nick", {27'd0, oLSB_commit_nick}, {27'd0, mon_e.nick});
                end else begin
                    check("rf_rd", {27'd0, oRF_rd_regnm}, {27'd0, mon_e.rd});
                    check("rf_dt", oRF_rd_dt, mon_e.dt);
                    check("rf_nick", {27'd0, oRF_rd_nick}, {27'd0, mon_e.nick});
                end
            end
        end
    end

    task automatic push(input logic st, input logic [4:0] rd, input logic [31:0] dt, input logic [4:0] nick);
        exp_t e;
        e.st = st; e.rd = rd; e.dt = dt; e.nick = nick;
        sb.push_back(e);
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic [1:0] kind, input logic pd,
                            input logic [4:0] exp_nick, input logic exp_nen);
        iDP_en = 1'b1; iDP_rd_regnm = rd; iDP_kind = kind; iDP_pd = pd;
        #1;
        check("dp_nick", {27'd0, oDP_nick}, {27'd0, exp_nick});
        check("nick_en", {31'd0, oRF_nick_en}, {31'd0, exp_nen});
        if (exp_nen) begin
            check("nick_regnm", {27'd0, oRF_nick_regnm}, {27'd0, rd});
        end
        @(posedge clk); #1;
        iDP_en = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] nick, input logic [31:0] dt, input logic jump, input logic [31:0] target);
        iCDB_en = 1'b1; iCDB_nick = nick; iCDB_dt = dt; iCDB_jump = jump; iCDB_target = target;
        @(posedge clk); #1;
        iCDB_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_left", sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{5'd5, 2'd0, 1'b0, 1'b0, 32'h1234, 5'd1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{5'd0, 2'd0, 1'b0, 1'b0, 32'hdead, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{5'd7, 2'd1, 1'b0, 1'b0, 32'hbeef, 5'd3, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{5'd9, 2'd2, 1'b0, 1'b0, 32'h0044, 5'd4, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{5'd0, 2'd2, 1'b1, 1'b1, 32'h0055, 5'd5, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{5'd3, 2'd0, 1'b0, 1'b0, 32'hcafe, 5'd6, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; rdy = 1'b1;
        iDP_en = 1'b0; iDP_rd_regnm = 5'd0; iDP_kind = 2'd0; iDP_pd = 1'b0;
        iCDB_en = 1'b0; iCDB_nick = 5'd0; iCDB_dt = 32'd0; iCDB_jump = 1'b0; iCDB_target = 32'd0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;

        check("rst_full", {31'd0, oFull}, 32'd0);
        check("rst_nick", {27'd0, oDP_nick}, 32'd1);
        check("rst_rf_en", {31'd0, oRF_en}, 32'd0);
        check("rst_lsb_en", {31'd0, oLSB_commit_en}, 32'd0);
        check("rst_clr", {31'd0, oClr}, 32'd0);
        check("rst_clr_pc", oClr_pc, 32'd0);

        // Single-instruction lifecycles with exact commit latency.
        for (int i = 0; i < 6; i++) begin
            dispatch(vecs[i].rd, vecs[i].kind, vecs[i].pd, vecs[i].exp_nick, vecs[i].exp_nen);
            if (vecs[i].exp_rf) push(1'b0, vecs[i].rd, vecs[i].dt, vecs[i].exp_nick);
            if (vecs[i].exp_lsb) push(1'b1, 5'd0, 32'd0, vecs[i].exp_nick);
            cdb(vecs[i].exp_nick, vecs[i].dt, vecs[i].jump, 32'h0);
            @(negedge clk);
            check("early_rf_en", {31'd0, oRF_en}, 32'd0);
            check("early_lsb_en", {31'd0, oLSB_commit_en}, 32'd0);
            @(negedge clk);
            check("vec_rf_en", {31'd0, oRF_en}, {31'd0, vecs[i].exp_rf});
            check("vec_lsb_en", {31'd0, oLSB_commit_en}, {31'd0, vecs[i].exp_lsb});
            check("vec_clr", {31'd0, oClr}, 32'd0);
            @(posedge clk); #1;
        end
        wait_idle(10);

        // Out-of-order completion retires in order on consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            dispatch(5'(i + 1), 2'd0, 1'b0, 5'(7 + i), 1'b1);
            push(1'b0, 5'(i + 1), 32'h700 + i, 5'(7 + i));
        end
        cdb(5'd9, 32'h702, 1'b0, 32'h0);
        cdb(5'd7, 32'h700, 1'b0, 32'h0);
        cdb(5'd8, 32'h701, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ooo_rf_en", {31'd0, oRF_en}, 32'd1);
            check("ooo_nick", {27'd0, oRF_rd_nick}, 32'(7 + i));
        end
        @(posedge clk); #1;
        wait_idle(10);

        // Fill, overflow attempt, then wrap-around of the tag.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dispatch(5'(i + 1), 2'd0, 1'b0, 5'(i + 1), 1'b1);
            push(1'b0, 5'(i + 1), 32'h3000 + i, 5'(i + 1));
        end
        check("full_set", {31'd0, oFull}, 32'd1);
        iDP_en = 1'b1; iDP_rd_regnm = 5'd20; iDP_kind = 2'd0; iDP_pd = 1'b0;
        #1;
        check("full_nick_en", {31'd0, oRF_nick_en}, 32'd0);
        @(posedge clk); #1;
        iDP_en = 1'b0;
        check("full_hold", {31'd0, oFull}, 32'd1);
        cdb(5'd1, 32'h3000, 1'b0, 32'h0);
        @(posedge clk); #1;
        check("full_clear", {31'd0, oFull}, 32'd0);
        dispatch(5'd21, 2'd0, 1'b0, 5'd1, 1'b1);
        push(1'b0, 5'd21, 32'h3100, 5'd1);
        for (int n = 2; n <= 16; n++) cdb(5'(n), 32'h3000 + 32'(n - 1), 1'b0, 32'h0);
        cdb(5'd1, 32'h3100, 1'b0, 32'h0);
        wait_idle(40);

        // Mispredicted branch flushes younger completed entries.
        dispatch(5'd0, 2'd2, 1'b0, 5'd2, 1'b0);
        dispatch(5'd11, 2'd0, 1'b0, 5'd3, 1'b1);
        dispatch(5'd12, 2'd0, 1'b0, 5'd4, 1'b1);
        cdb(5'd3, 32'h11, 1'b0, 32'h0);
        cdb(5'd4, 32'h12, 1'b0, 32'h0);
        cdb(5'd2, 32'h0, 1'b1, 32'h100);
        @(negedge clk);
        check("clr_early", {31'd0, oClr}, 32'd0);
        @(posedge clk); #1;
        check("clr_set", {31'd0, oClr}, 32'd1);
        check("clr_pc", oClr_pc, 32'h100);
        check("clr_rf_en", {31'd0, oRF_en}, 32'd0);
        dispatch(5'd0, 2'd1, 1'b0, 5'd1, 1'b0);
        push(1'b1, 5'd0, 32'd0, 5'd1);
        check("clr_width", {31'd0, oClr}, 32'd0);
        check("clr_pc_clear", oClr_pc, 32'd0);
        cdb(5'd1, 32'h0, 1'b0, 32'h0);
        wait_idle(10);

        // rdy low holds back a ready head, which commits once rdy returns.
        dispatch(5'd20, 2'd0, 1'b0, 5'd2, 1'b1);
        push(1'b0, 5'd20, 32'h600, 5'd2);
        cdb(5'd2, 32'h600, 1'b0, 32'h0);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rdy_low_rf_en", {31'd0, oRF_en}, 32'd0);
        end
        rdy = 1'b1;
        @(negedge clk);
        check("rdy_high_rf_en", {31'd0, oRF_en}, 32'd1);
        check("rdy_high_nick", {27'd0, oRF_rd_nick}, 32'd2);
        @(posedge clk); #1;
        wait_idle(5);

        // Reset with entries in flight discards them.
        for (int i = 0; i < 3; i++) dispatch(5'(i + 1), 2'd0, 1'b0, 5'(3 + i), 1'b1);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        check("mid_rst_nick", {27'd0, oDP_nick}, 32'd1);
        check("mid_rst_full", {31'd0, oFull}, 32'd0);
        cdb(5'd1, 32'h999, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        dispatch(5'd6, 2'd0, 1'b0, 5'd1, 1'b1);
        push(1'b0, 5'd6, 32'h777, 5'd1);
        cdb(5'd1, 32'h777, 1'b0, 32'h0);
        wait_idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
